// File: rtl/program_counter.sv
// Architectural PC register for the IF stage of the 5-stage RISC core.
// Captures the upstream next-PC value every clock; no next-PC arithmetic here.
// Optional feature: define PC_STALL_EN to add a stall input (holds the PC) and
// a registered misaligned flag for the most recently loaded PC_in.
module program_counter #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned ALIGN_BITS   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PC_in,
`ifdef PC_STALL_EN
  input  logic             stall,
  output logic             misaligned,
`endif
  output logic [WIDTH-1:0] PC_out
);

  // Clears the low ALIGN_BITS bits; all ones when ALIGN_BITS is 0.
  localparam logic [WIDTH-1:0] AlignMask =
    ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));
  localparam logic [WIDTH-1:0] ResetPc = WIDTH'(RESET_VECTOR) & AlignMask;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Aligned version of the incoming next-PC.
  always_comb begin
    pc_d = PC_in & AlignMask;
  end

`ifdef PC_STALL_EN
  logic misaligned_q;

  // PC register: reset > stall > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= ResetPc;
      misaligned_q <= 1'b0;
    end else if (!stall) begin
      pc_q         <= pc_d;
      // Flag reflects the raw PC_in, before alignment masking.
      misaligned_q <= |PC_in[1:0];
    end
  end

  assign misaligned = misaligned_q;
`else
  // PC register: reset, otherwise load every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end
`endif

  assign PC_out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed steps plus a random phase,
// checked against an arithmetic reference model. Two instances: defaults, and
// a word-aligned one with a non-zero, unaligned reset vector.
module tb_program_counter;

  localparam logic [31:0] Rv1 = 32'h0000_1003;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] pc_out0;
  logic [31:0] pc_out1;
`ifdef PC_STALL_EN
  logic        stall;
  logic        mis0;
  logic        mis1;
`endif

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // Reference model state
  longint unsigned e0;
  longint unsigned e1;
  bit              em;

  program_counter dut0 (
    .clk       (clk),
    .reset     (reset),
    .PC_in     (pc_in),
`ifdef PC_STALL_EN
    .stall     (stall),
    .misaligned(mis0),
`endif
    .PC_out    (pc_out0)
  );

  program_counter #(
    .WIDTH       (32),
    .RESET_VECTOR(Rv1),
    .ALIGN_BITS  (2)
  ) dut1 (
    .clk       (clk),
    .reset     (reset),
    .PC_in     (pc_in),
`ifdef PC_STALL_EN
    .stall     (stall),
    .misaligned(mis1),
`endif
    .PC_out    (pc_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input longint unsigned exp);
    logic [31:0] e;
    e = exp[31:0];
    n_cmp++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/pc0"}, pc_out0, e0);
    chk({tag, "/pc1"}, pc_out1, e1);
`ifdef PC_STALL_EN
    chk({tag, "/mis0"}, {31'd0, mis0}, em);
    chk({tag, "/mis1"}, {31'd0, mis1}, em);
`endif
  endtask

  // Drive inputs, take one edge, advance the model, check 1 ns after the edge.
  task automatic step(input logic r, input logic [31:0] d, input logic s, input string tag);
    longint unsigned v;
    reset = r;
    pc_in = d;
`ifdef PC_STALL_EN
    stall = s;
`endif
    @(posedge clk);
    v = d;
    if (r) begin
      e0 = 0;
      e1 = (Rv1 / 4) * 4;
      em = 1'b0;
`ifdef PC_STALL_EN
    end else if (s) begin
      // hold
`endif
    end else begin
      e0 = v;
      e1 = (v / 4) * 4;
      em = (v % 4) != 0;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    pc_in = 32'h0;
`ifdef PC_STALL_EN
    stall = 1'b0;
`endif
    e0 = 0;
    e1 = 0;
    em = 1'b0;
    #1;

    // Reset wins over PC_in
    step(1'b1, 32'h0000_0040, 1'b0, "reset_load");

    // Reset held for 20 cycles while PC_in keeps changing
    for (int i = 0; i < 20; i++) step(1'b1, 32'(i + 1), 1'b0, "reset_held");

    // First edges after reset release load PC_in
    step(1'b0, 32'h1, 1'b0, "load1");
    step(1'b0, 32'h2, 1'b0, "load2");
    step(1'b0, 32'h3, 1'b0, "load3");

    // PC_in wiggles between edges; only the value at the edge matters
    pc_in = 32'h10;
    #2 pc_in = 32'h20;
    #1 check_all("mid_hold_a");
    #1 pc_in = 32'h10;
    #1 check_all("mid_hold_b");
    step(1'b0, 32'h10, 1'b0, "mid_edge");

    // Reset raised between edges takes effect at the next edge only
    step(1'b0, 32'h0000_1234, 1'b0, "pre_reset");
    #2 reset = 1'b1;
    #2 check_all("reset_pending");
    step(1'b1, 32'h0000_1234, 1'b0, "reset_edge");

    // Alignment and all-ones boundary
    step(1'b0, 32'h0000_0007, 1'b0, "align7");
    step(1'b0, 32'hFFFF_FFFF, 1'b0, "all_ones");
    step(1'b0, 32'h0000_0000, 1'b0, "wrap_zero");

`ifdef PC_STALL_EN
    step(1'b0, 32'h0000_0006, 1'b0, "mis_load6");
    step(1'b0, 32'h0000_0100, 1'b1, "stall_hold");
    step(1'b1, 32'h0000_0100, 1'b1, "reset_over_stall");
    step(1'b0, 32'h0000_0104, 1'b0, "after_stall");
`endif

    // Random phase
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 3) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
